// File: rtl/apb_slv_pkg.sv
// ----------------------------------------------------------------------------
// apb_slv_pkg: shared types, widths and address decode for apb_slave_mem. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package apb_slv_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Address is zero-extended by the caller; bits above the word index count toward range.
  function automatic logic decode_err(input logic [31:0] paddr, input int unsigned depth);
    return (paddr[1:0] != 2'b00) || ((paddr >> 2) >= depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_slave_mem_if.sv
// ----------------------------------------------------------------------------
// apb_slave_mem_if: APB3/APB4 bus bundle with requester and completer views. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface apb_slave_mem_if #(
  parameter int ADDR_W = 12
);
  import apb_slv_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

`default_nettype wire

// File: rtl/apb_slv_ram.sv
// ----------------------------------------------------------------------------
// apb_slv_ram: single-port synchronous RAM with byte enables and registered read. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apb_slv_ram
  import apb_slv_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [STRB_W-1:0] i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read data register only updates on reads, so it holds across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ----------------------------------------------------------------------------
// apb_slave_mem: APB3 completer over a word RAM with WAIT_CYCLES wait states.
// Define APB_SLV_PSTRB_EN for APB4 byte-lane writes. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           pclk,
  input  logic           preset,
  apb_slave_mem_if.slave apb
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  state_e            r_state;
  logic [3:0]        r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic              r_err;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_be;
  logic              r_rd_ok;
  logic              r_pready;
  logic              r_pslverr;

  logic              w_setup;
  logic              w_to_resp;
  logic              w_bus_err;
  logic              w_wr_sel;
  logic              w_err_sel;
  logic              w_rd_en;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_bus_idx;
  logic [IDX_W-1:0]  w_ram_idx;
  logic [STRB_W-1:0] w_bus_be;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_setup   = apb.psel && !apb.penable;
  assign w_bus_idx = apb.paddr[IDX_W+1:2];
  assign w_bus_err = decode_err(32'(apb.paddr), int'(DEPTH));

`ifdef APB_SLV_PSTRB_EN
  assign w_bus_be = apb.pstrb;
`else
  logic w_unused_strb;
  assign w_bus_be      = '1;
  assign w_unused_strb = ^apb.pstrb;
`endif

  always_comb begin
    w_to_resp = 1'b0;
    case (r_state)
      ST_IDLE: w_to_resp = w_setup && (C_WAIT == 4'd0);
      ST_WAIT: w_to_resp = apb.psel && (r_cnt == 4'd1);
      default: w_to_resp = 1'b0;
    endcase
  end

  // Zero-wait reads must hit the RAM on the setup edge, so IDLE uses the live bus fields.
  assign w_wr_sel  = (r_state == ST_IDLE) ? apb.pwrite : r_write;
  assign w_err_sel = (r_state == ST_IDLE) ? w_bus_err  : r_err;
  assign w_ram_idx = (r_state == ST_IDLE) ? w_bus_idx  : r_idx;
  assign w_rd_en   = w_to_resp && !w_wr_sel && !w_err_sel;
  assign w_wr_en   = (r_state == ST_RESP) && r_write && !r_err && !preset;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_rd_ok   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= w_to_resp;
      r_pslverr <= w_to_resp && w_err_sel;
      if (w_to_resp) begin
        r_rd_ok <= w_wr_sel ? (r_rd_ok && !w_err_sel) : !w_err_sel;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_cnt   <= C_WAIT;
            r_state <= (C_WAIT == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!apb.psel) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= ST_RESP;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if ((r_state == ST_IDLE) && w_setup) begin
      r_idx   <= w_bus_idx;
      r_write <= apb.pwrite;
      r_err   <= w_bus_err;
      r_wdata <= apb.pwdata;
      r_be    <= w_bus_be;
    end
  end

  apb_slv_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (pclk),
    .i_en    (w_rd_en || w_wr_en),
    .i_we    (w_wr_en),
    .i_addr  (w_ram_idx),
    .i_be    (r_be),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Errors and reset force zero read data; the RAM output register itself is never cleared.
  assign apb.prdata  = r_rd_ok ? w_ram_rdata : '0;
  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;

endmodule

`default_nettype wire
